sisc_ctrl_mc: RTL and testbench

Parametrised multi-cycle control unit for the SISC datapath; next-generation controller with variable-latency memories. Sequences START/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT and skips states an opcode does not need. Adds instruction- and data-memory request/acknowledge handshakes with a bounded wait timeout, a dual-write SWP, and a real HALT state with a resume input instead of simulation stop. Sits between the instruction register/status register and the datapath muxes and enables.

---
 rtl/sisc_pkg.sv | 31 +++
 rtl/ctrl_wait_timer.sv | 25 ++
 rtl/sisc_ctrl_mc.sv | 161 ++++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multi-cycle controller: opcodes, FSM states,
// addressing-mode default and datapath mux selects.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_LOD  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_SWP  = 4'h3;
  localparam logic [3:0] OP_BRA  = 4'h4;
  localparam logic [3:0] OP_BRR  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BNR  = 4'h7;
  localparam logic [3:0] OP_ALU  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam int AM_IMM_DEF = 8;

  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_SWP0 = 2'b10;
  localparam logic [1:0] WB_SWP1 = 2'b11;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive wait cycles; expire fires combinationally on the
// TIMEOUT-th wait cycle. TIMEOUT=0 never expires.
module ctrl_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic wait_cyc,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)        cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (wait_cyc) cnt <= cnt + CW'(1);
  end

  assign expire = (TIMEOUT != 0) && wait_cyc && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sisc_ctrl_mc.sv
// Multi-cycle SISC controller with im/dm handshakes, bounded waits and HALT/resume.
// Outputs decode combinationally from state; waits stretch FETCH/MEM until ack or timeout.
module sisc_ctrl_mc
  import sisc_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MM_W    = 4,
  parameter int AM_IMM  = AM_IMM_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [OP_W-1:0] opcode,
  input  logic [MM_W-1:0] mm,
  input  logic [MM_W-1:0] stat,
  input  logic            im_ack,
  input  logic            dm_ack,
  input  logic            resume,
  output logic            im_req,
  output logic            dm_req,
  output logic            ir_load,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            pc_rst,
  output logic            br_sel,
  output logic            rf_we,
  output logic            rb_sel,
  output logic            mm_sel,
  output logic            dm_we,
  output logic [1:0]      alu_op,
  output logic [1:0]      wb_sel,
  output logic            halted,
  output logic            fault
);

  state_t state, state_nxt;
  logic   phase, phase_nxt, fault_nxt;
  logic   wait_cyc, expire;

  logic is_lod, is_str, is_swp, is_alu, is_hlt, is_bra, is_brr, is_bne, is_bnr;
  logic imm_mode, any_hit, taken;

  assign is_lod = (opcode == OP_W'(OP_LOD));
  assign is_str = (opcode == OP_W'(OP_STR));
  assign is_swp = (opcode == OP_W'(OP_SWP));
  assign is_alu = (opcode == OP_W'(OP_ALU));
  assign is_hlt = (opcode == OP_W'(OP_HLT));
  assign is_bra = (opcode == OP_W'(OP_BRA));
  assign is_brr = (opcode == OP_W'(OP_BRR));
  assign is_bne = (opcode == OP_W'(OP_BNE));
  assign is_bnr = (opcode == OP_W'(OP_BNR));

  assign imm_mode = (mm == MM_W'(AM_IMM));
  assign any_hit  = |(mm & stat);
  assign taken    = ((is_bra || is_brr) && any_hit) || ((is_bne || is_bnr) && !any_hit);

  assign wait_cyc = ((state == S_FETCH) && !im_ack) || ((state == S_MEM) && !dm_ack);

  ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_f    (rst_f),
    .clr      (state_nxt != state),
    .wait_cyc (wait_cyc),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= S_START;
      phase <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      fault <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = 1'b0;
    fault_nxt = fault;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    pc_rst    = 1'b0;
    br_sel    = 1'b0;
    rf_we     = 1'b0;
    rb_sel    = 1'b0;
    mm_sel    = 1'b0;
    dm_we     = 1'b0;
    alu_op    = ALU_PASS;
    wb_sel    = WB_ALU;
    halted    = 1'b0;
    unique case (state)
      S_START: begin
        pc_rst    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_load   = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (expire) begin
          state_nxt = S_HALT;
          fault_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        pc_sel   = 1'b1;
        br_sel   = is_bra || is_bne;
        pc_write = taken;
        if (is_hlt)                                     state_nxt = S_HALT;
        else if (is_lod || is_str || is_swp || is_alu)  state_nxt = S_EXECUTE;
        else                                            state_nxt = S_FETCH;
      end
      S_EXECUTE: begin
        if (is_alu) alu_op = imm_mode ? ALU_IMM : ALU_REG;
        if (is_lod || is_str)      state_nxt = S_MEM;
        else if (is_alu || is_swp) state_nxt = S_WB;
        else                       state_nxt = S_FETCH;
      end
      S_MEM: begin
        dm_req = 1'b1;
        rb_sel = 1'b1;
        mm_sel = imm_mode;
        dm_we  = is_str;
        if (dm_ack) begin
          rf_we     = is_lod;
          wb_sel    = is_lod ? WB_MEM : WB_ALU;
          state_nxt = S_FETCH;
        end else if (expire) begin
          state_nxt = S_HALT;
          fault_nxt = 1'b1;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        // SWP writes both registers over two cycles, steered by the phase bit
        if (is_swp) begin
          wb_sel    = phase ? WB_SWP1 : WB_SWP0;
          phase_nxt = ~phase;
          state_nxt = phase ? S_FETCH : S_WB;
        end else begin
          alu_op    = imm_mode ? ALU_IMM : ALU_REG;
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_START;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Bench for sisc_ctrl_mc: instruction-level trace model builds expected per-cycle
// outputs and ack/resume stimulus; each cycle is compared after the inputs settle.
module tb_sisc_ctrl_mc;
  import sisc_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = '0, mm = '0, stat = '0;
  logic       im_ack = 1'b0, dm_ack = 1'b0, resume = 1'b0;
  logic       im_req, dm_req, ir_load, pc_write, pc_sel, pc_rst, br_sel;
  logic       rf_we, rb_sel, mm_sel, dm_we, halted, fault;
  logic [1:0] alu_op, wb_sel;

  sisc_ctrl_mc #(.OP_W(4), .MM_W(4), .AM_IMM(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .im_ack(im_ack), .dm_ack(dm_ack), .resume(resume),
    .im_req(im_req), .dm_req(dm_req), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .pc_rst(pc_rst), .br_sel(br_sel), .rf_we(rf_we),
    .rb_sel(rb_sel), .mm_sel(mm_sel), .dm_we(dm_we), .alu_op(alu_op),
    .wb_sel(wb_sel), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic im_req, dm_req, ir_load, pc_write, pc_sel, pc_rst, br_sel;
    logic rf_we, rb_sel, mm_sel, dm_we;
    logic [1:0] alu_op, wb_sel;
    logic halted, fault;
  } out_t;

  typedef struct packed {
    logic [3:0] op, mm, stat;
    logic ia, da, rs;
    out_t exp;
  } step_t;

  step_t      trace[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       mfault = 1'b0;
  logic [3:0] cur_op, cur_mm, cur_stat;

  function automatic out_t idle();
    out_t o = '0;
    o.alu_op = 2'b10;
    o.fault  = mfault;
    return o;
  endfunction

  function automatic out_t obs();
    out_t o;
    o.im_req = im_req;   o.dm_req = dm_req;   o.ir_load = ir_load;
    o.pc_write = pc_write; o.pc_sel = pc_sel; o.pc_rst = pc_rst;
    o.br_sel = br_sel;   o.rf_we = rf_we;     o.rb_sel = rb_sel;
    o.mm_sel = mm_sel;   o.dm_we = dm_we;     o.alu_op = alu_op;
    o.wb_sel = wb_sel;   o.halted = halted;   o.fault = fault;
    return o;
  endfunction

  task automatic push(input out_t o, input logic ia, input logic da, input logic rs);
    step_t s;
    s.op = cur_op; s.mm = cur_mm; s.stat = cur_stat;
    s.ia = ia; s.da = da; s.rs = rs; s.exp = o;
    trace.push_back(s);
  endtask

  task automatic add_halt(input int hold);
    out_t o;
    for (int i = 0; i < hold; i++) begin
      o = idle(); o.halted = 1'b1; push(o, 1'b0, 1'b0, 1'b0);
    end
    o = idle(); o.halted = 1'b1; push(o, 1'b0, 1'b0, 1'b1);
  endtask

  // One instruction: di/dd = wait cycles before im/dm ack; >= TO means never acked.
  task automatic build_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] st,
                             input int di, input int dd);
    out_t o;
    logic hit, imm;
    cur_op = op; cur_mm = m; cur_stat = st;
    hit = (m & st) != 4'd0;
    imm = (m == 4'd8);
    for (int i = 0; i < di && i < TO; i++) begin
      o = idle(); o.im_req = 1'b1; push(o, 1'b0, 1'b0, 1'b0);
    end
    if (di >= TO) begin mfault = 1'b1; add_halt(2); return; end
    o = idle(); o.im_req = 1'b1; o.ir_load = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1, 1'b0, 1'b0);
    o = idle(); o.pc_sel = 1'b1;
    case (op)
      OP_BRA: begin o.br_sel = 1'b1; o.pc_write = hit;  end
      OP_BNE: begin o.br_sel = 1'b1; o.pc_write = !hit; end
      OP_BRR: o.pc_write = hit;
      OP_BNR: o.pc_write = !hit;
      default: ;
    endcase
    push(o, 1'b0, 1'b0, 1'b0);
    if (op == OP_HLT) begin add_halt(2); return; end
    if (!(op == OP_LOD || op == OP_STR || op == OP_SWP || op == OP_ALU)) return;
    o = idle();
    if (op == OP_ALU) o.alu_op = imm ? 2'b01 : 2'b00;
    push(o, 1'b0, 1'b0, 1'b0);
    if (op == OP_ALU) begin
      o = idle(); o.rf_we = 1'b1; o.alu_op = imm ? 2'b01 : 2'b00; o.wb_sel = 2'b00;
      push(o, 1'b0, 1'b0, 1'b0);
    end else if (op == OP_SWP) begin
      o = idle(); o.rf_we = 1'b1; o.wb_sel = 2'b10; push(o, 1'b0, 1'b0, 1'b0);
      o = idle(); o.rf_we = 1'b1; o.wb_sel = 2'b11; push(o, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < dd && i < TO; i++) begin
        o = idle(); o.dm_req = 1'b1; o.rb_sel = 1'b1; o.mm_sel = imm;
        o.dm_we = (op == OP_STR);
        push(o, 1'b0, 1'b0, 1'b0);
      end
      if (dd >= TO) begin mfault = 1'b1; add_halt(1); return; end
      o = idle(); o.dm_req = 1'b1; o.rb_sel = 1'b1; o.mm_sel = imm;
      o.dm_we = (op == OP_STR);
      if (op == OP_LOD) begin o.rf_we = 1'b1; o.wb_sel = 2'b01; end
      push(o, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic run_trace(input string name, input int limit);
    step_t s;
    out_t  got;
    int    n = 0;
    while (trace.size() > 0 && n < limit) begin
      s = trace.pop_front();
      @(negedge clk);
      opcode = s.op; mm = s.mm; stat = s.stat;
      im_ack = s.ia; dm_ack = s.da; resume = s.rs;
      #1;
      got = obs();
      vectors++;
      if (got !== s.exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, got, s.exp);
      end
      n++;
    end
    trace.delete();
  endtask

  task automatic check_start(input string name);
    out_t exp, got;
    exp = idle(); exp.pc_rst = 1'b1;
    got = obs();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_start("reset_held");
    rst_f = 1'b1;
    #1;
    check_start("reset_release_cycle");
    build_instr(OP_NOOP, 4'd0, 4'd0, 0, 0);
    run_trace("first_fetch", 1000);
  endtask

  task automatic test_alu_imm();
    build_instr(OP_ALU, 4'd8, 4'd0, 0, 0);
    build_instr(OP_ALU, 4'd3, 4'd0, 0, 0);
    build_instr(OP_NOOP, 4'd0, 4'd0, 0, 0);
    run_trace("alu", 1000);
  endtask

  task automatic test_branches();
    build_instr(OP_BNE, 4'd4, 4'd0, 0, 0);
    build_instr(OP_BNE, 4'd4, 4'd4, 0, 0);
    build_instr(OP_BRA, 4'd6, 4'd2, 0, 0);
    build_instr(OP_BRR, 4'd1, 4'd2, 0, 0);
    build_instr(OP_BNR, 4'd1, 4'd2, 0, 0);
    build_instr(OP_NOOP, 4'd0, 4'd0, 0, 0);
    run_trace("branch", 1000);
  endtask

  task automatic test_lod_delay();
    build_instr(OP_LOD, 4'd8, 4'd0, 0, 3);
    build_instr(OP_STR, 4'd2, 4'd0, 1, 2);
    run_trace("lod_str_delay", 1000);
  endtask

  task automatic test_swp();
    build_instr(OP_SWP, 4'd0, 4'd0, 0, 0);
    build_instr(OP_SWP, 4'd8, 4'd0, 2, 0);
    run_trace("swp", 1000);
  endtask

  task automatic test_random();
    logic [3:0] ops [10];
    int di, dd;
    ops = '{OP_NOOP, OP_LOD, OP_STR, OP_SWP, OP_BRA, OP_BRR, OP_BNE, OP_BNR, OP_ALU, 4'h9};
    for (int k = 0; k < 40; k++) begin
      di = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
      dd = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
      build_instr(ops[$urandom_range(0, 9)],
                  ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), di, dd);
    end
    run_trace("random", 100000);
  endtask

  task automatic test_halt();
    build_instr(OP_HLT, 4'd0, 4'd0, 0, 0);
    build_instr(OP_NOOP, 4'd0, 4'd0, 0, 0);
    run_trace("halt_resume", 1000);
  endtask

  task automatic test_timeout_fetch();
    build_instr(OP_NOOP, 4'd0, 4'd0, TO, 0);
    build_instr(OP_ALU, 4'd8, 4'd0, 0, 0);
    run_trace("timeout_fetch", 1000);
  endtask

  task automatic test_timeout_mem();
    build_instr(OP_LOD, 4'd0, 4'd0, 0, TO);
    build_instr(OP_BRA, 4'd1, 4'd1, 0, 0);
    run_trace("timeout_mem", 1000);
  endtask

  task automatic test_reset_mid_str();
    build_instr(OP_STR, 4'd8, 4'd0, 0, 6);
    run_trace("str_before_reset", 5);
    #2;
    rst_f = 1'b0;
    mfault = 1'b0;
    #1;
    check_start("reset_mid_str");
    @(negedge clk);
    im_ack = 1'b0; dm_ack = 1'b0; resume = 1'b0;
    rst_f = 1'b1;
    #1;
    check_start("reset_mid_str_release");
    build_instr(OP_NOOP, 4'd0, 4'd0, 0, 0);
    run_trace("fetch_after_reset", 1000);
  endtask

  initial begin
    test_reset();
    test_alu_imm();
    test_branches();
    test_lod_delay();
    test_swp();
    test_random();
    test_halt();
    test_timeout_fetch();
    test_timeout_mem();
    test_reset_mid_str();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
